// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: arbitrates NUM_PORTS line-wide requesters onto one memory master, one transaction at a time
module cache_mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter bit RR_MODE = 1'b1,
  parameter logic [NUM_PORTS-1:0] FULL_BE_MASK = '1,
  parameter int TIMEOUT = 0,
  localparam int BE_W = LINE_W / 8,
  localparam int GW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*LINE_W-1:0] req_writedata,
  input  logic [NUM_PORTS*BE_W-1:0]   req_byteenable,
  output logic [NUM_PORTS-1:0]        req_waitrequest,
  output logic [LINE_W-1:0]           req_readdata,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [LINE_W-1:0]           mem_writedata,
  output logic [BE_W-1:0]             mem_byteenable,
  input  logic                        mem_waitrequest,
  input  logic [LINE_W-1:0]           mem_readdata,
  output logic [GW-1:0]               grant_idx,
  output logic                        stall_err
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, last_q, last_d, win;
  logic rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wd_q, wd_d;
  logic [BE_W-1:0] be_q, be_d;
  logic [NUM_PORTS-1:0] req;
  int idx;
  assign req = req_read | req_write;
  assign req_readdata = mem_readdata;
  assign mem_address = addr_q;
  assign mem_read = rd_q;
  assign mem_write = wr_q;
  assign mem_writedata = wd_q;
  assign mem_byteenable = be_q;
  assign grant_idx = grant_q;
  assign stall_err = err_q;
  // Searching downward lets the nearest candidate overwrite the others
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = RR_MODE ? (int'(last_q) + k) % NUM_PORTS : k - 1;
      if (req[idx]) win = GW'(idx);
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    rd_d = rd_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wd_d = wd_q;
    be_d = be_q;
    if (state_q == IDLE && |req) begin
      state_d = BUSY;
      grant_d = win;
      rd_d = req_read[win];
      wr_d = req_write[win];
      addr_d = req_address[int'(win)*ADDR_W +: ADDR_W] & ~ADDR_W'(BE_W - 1);
      wd_d = req_writedata[int'(win)*LINE_W +: LINE_W];
      be_d = FULL_BE_MASK[win] ? '1 : req_byteenable[int'(win)*BE_W +: BE_W];
    end else if (state_q == BUSY && !mem_waitrequest) begin
      state_d = IDLE;
      rd_d = 1'b0;
      wr_d = 1'b0;
      last_d = grant_q;
    end
  end
  // Watchdog counts stalled BUSY cycles and saturates at TIMEOUT
  always_comb begin
    cnt_d = (state_q == BUSY && mem_waitrequest) ?
            ((TIMEOUT > 0 && cnt_q != CW'(TIMEOUT)) ? cnt_q + CW'(1) : cnt_q) : '0;
    err_d = err_q | (TIMEOUT > 0 && cnt_d == CW'(TIMEOUT));
  end
  always_comb begin
    req_waitrequest = '1;
    if (state_q == BUSY) req_waitrequest[grant_q] = mem_waitrequest;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q <= GW'(NUM_PORTS - 1);
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    wd_q <= wd_d;
    be_q <= be_d;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Parametrised successor to the single-cache/single-bypass memory router.
- Arbitrates NUM_PORTS line-wide requesters onto one line-wide memory master. Requesters are cache miss/writeback engines and uncached core bypass paths.
- Round-robin or fixed priority; one outstanding memory transaction; per-port full-line byteenable forcing; optional stall watchdog.
- Sits between the per-core cache controllers and the system interconnect.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..8)
- ADDR_W, 32, byte address width
- LINE_W, 128, line data width in bits (power of two, >=32)
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- FULL_BE_MASK, all-ones of NUM_PORTS, bit i set forces all-ones mem_byteenable for port i
- TIMEOUT, 0, BUSY cycles before stall_err; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_address  in  NUM_PORTS*ADDR_W  per-port byte address, port i at slice i
- req_read  in  NUM_PORTS  per-port read request
- req_write  in  NUM_PORTS  per-port write request
- req_writedata  in  NUM_PORTS*LINE_W  per-port write line
- req_byteenable  in  NUM_PORTS*(LINE_W/8)  per-port byte enables
- req_waitrequest  out  NUM_PORTS  per-port stall
- req_readdata  out  LINE_W  shared read line; valid for the granted port when its waitrequest is low
- mem_address  out  ADDR_W  line-aligned address
- mem_read  out  1  memory read
- mem_write  out  1  memory write
- mem_writedata  out  LINE_W  write line
- mem_byteenable  out  LINE_W/8  byte enables
- mem_waitrequest  in  1  memory stall
- mem_readdata  in  LINE_W  memory read line
- grant_idx  out  $clog2(NUM_PORTS) min 1  current or last granted port
- stall_err  out  1  sticky watchdog flag

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - mem_read = mem_write = 0
  - grant_idx = 0
  - last_grant = NUM_PORTS-1, so port 0 wins first under RR
  - stall_err = 0, watchdog counter = 0
  - mem_address, mem_writedata, mem_byteenable are data-only and not reset
- Request rules:
  - A port requests when req_read|req_write is high.
  - It must hold the request and its data stable until its req_waitrequest is low for one cycle.
  - Read and write asserted together on one port is illegal; the bench asserts on it.
- IDLE state:
  - All req_waitrequest = 1.
  - If any port requests, pick the winner combinationally.
  - RR_MODE=1: first requesting index searching upward from last_grant+1 modulo NUM_PORTS.
  - RR_MODE=0: lowest requesting index.
  - On the edge, register grant_idx = winner and mem_read/mem_write = winner's read/write.
  - mem_address = winner address with the low $clog2(LINE_W/8) bits zeroed.
  - mem_writedata = winner data.
  - mem_byteenable = all-ones if FULL_BE_MASK[winner], else winner byteenable.
  - Go to BUSY.
- BUSY state:
  - req_waitrequest[grant_idx] = mem_waitrequest; all other ports = 1.
  - req_readdata = mem_readdata (combinational passthrough in all states).
  - On !mem_waitrequest: clear mem_read/mem_write, set last_grant = grant_idx, return to IDLE.
- Latency:
  - Grant is one cycle after the request is first seen in IDLE.
  - Completion is the same cycle as !mem_waitrequest.
  - Minimum 2 cycles per transaction; one IDLE bubble between back-to-back grants.
- Requests arriving during BUSY wait.
- Request withdrawn while granted is a protocol violation. The block still completes the mem transaction.
- Watchdog (TIMEOUT>0):
  - Counter increments each BUSY cycle with mem_waitrequest=1 and clears on leaving BUSY.
  - When it reaches TIMEOUT, stall_err sets and stays set until rst.
  - The transaction is never aborted; the counter saturates.
- Reset mid-transaction: outputs return to reset values immediately; the in-flight transfer is abandoned.

Test Plan:
- NUM_PORTS=2, RR: port0 read addr 0x1000_0004 alone, mem_waitrequest low 3 cycles after grant -> mem_address=0x1000_0000, mem_read 1 for 4 cycles, req_waitrequest[0] low exactly once with req_readdata=mem_readdata, grant_idx=0.
- Both ports request continuously, RR -> grants alternate 0,1,0,1; each transaction separated by one IDLE cycle; the loser's waitrequest stays 1 throughout.
- Same stimulus with RR_MODE=0 -> port0 wins every time while it requests; port1 is granted only after port0 drops.
- Port1 write with byteenable 0x000F and FULL_BE_MASK=2'b10 -> mem_byteenable=0xFFFF. With mask 2'b00 -> 0x000F, mem_writedata equals port1 data.
- TIMEOUT=8, mem_waitrequest held 1 -> stall_err rises after 8 BUSY cycles and stays 1 after completion and later transactions until rst.
- Assert rst while BUSY with mem_write=1 -> mem_write=0, all req_waitrequest=1, stall_err=0 in the same cycle. After release, next grant goes to port 0.
